uart_prog_loader: RTL

On-chip end of the UART program-download link. It receives 8N1 serial bytes on the user-project Rx pin, assembles them into little-endian 32-bit words, and writes them sequentially into the core's instruction memory. When the end-of-program marker arrives it raises prog_ready, which drives the ready GPIO and releases the core from hold.

---
 rtl/uart_loader_pkg.sv | 9 +
 rtl/uart_rx_byte.sv | 103 ++++++++++
 rtl/uart_prog_loader.sv | 101 ++++++++++
 3 files changed

// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART program loader (rx FSM states, widths, end marker).
// Pure definitions: no latency, no flow control.
package uart_loader_pkg;
    localparam int BYTE_W = 8;
    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] END_MARKER_DEF = 32'h0000_0FFF;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-flop sync, mid-bit sampling, one-cycle byte_valid; stop check under UART_FRAME_CHECK_EN.
// byte_valid rises one cycle after the mid-stop-bit sample; no backpressure, rx_en=0 parks it in IDLE.
module uart_rx_byte
    import uart_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 347
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_serial,
    input  logic              rx_en,
    output logic              byte_valid,
    output logic [BYTE_W-1:0] byte_data,
    output logic              frame_err
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic              sync1_q, sync2_q;
    rx_state_t         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [BYTE_W-1:0] shift_q, shift_d;
    logic              byte_valid_q, byte_valid_d;
    logic              frame_err_q, frame_err_d;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        byte_valid_d = 1'b0;
        frame_err_d  = frame_err_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rx_en && !sync2_q) state_d = START;
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d     = '0;
                    bit_idx_d = 3'd0;
                    // line back high at mid-start means it was only a glitch
                    state_d   = sync2_q ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {sync2_q, shift_q[BYTE_W-1:1]};
                    if (bit_idx_q == 3'd7) state_d = STOP;
                    else                   bit_idx_d = bit_idx_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
`ifdef UART_FRAME_CHECK_EN
                    if (sync2_q) byte_valid_d = 1'b1;
                    else         frame_err_d  = 1'b1;
`else
                    byte_valid_d = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= 3'd0;
            shift_q      <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            sync1_q      <= rx_serial;
            sync2_q      <= sync1_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign byte_valid = byte_valid_q;
    assign byte_data  = shift_q;
    assign frame_err  = frame_err_q;
endmodule

// File: rtl/uart_prog_loader.sv
// UART program loader: bytes -> little-endian words -> sequential imem writes; stop check under UART_FRAME_CHECK_EN.
// imem_we one cycle after the 4th byte_valid; no backpressure, input ignored once prog_ready is set.
module uart_prog_loader
    import uart_loader_pkg::*;
#(
    parameter int                CLKS_PER_BIT = 347,
    parameter int                ADDR_W       = 10,
    parameter logic [WORD_W-1:0] END_MARKER   = END_MARKER_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_serial,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              prog_ready,
    output logic              core_hold,
    output logic              frame_err
);
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    logic              byte_valid;
    logic [BYTE_W-1:0] byte_data;
    logic              rx_en;

    logic [1:0]          byte_idx_q, byte_idx_d;
    logic [23:0]         word_q, word_d;
    logic [ADDR_W-1:0]   count_q, count_d;
    logic                imem_we_q, imem_we_d;
    logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
    logic [WORD_W-1:0]   imem_wdata_q, imem_wdata_d;
    logic                prog_ready_q, prog_ready_d;
    logic [WORD_W-1:0]   full_word;

    assign rx_en = ~prog_ready_q;

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_serial  (rx_serial),
        .rx_en      (rx_en),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err)
    );

    always_comb begin
        byte_idx_d   = byte_idx_q;
        word_d       = word_q;
        count_d      = count_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        prog_ready_d = prog_ready_q;
        full_word    = {byte_data, word_q};
        if (byte_valid && !prog_ready_q) begin
            if (byte_idx_q == 2'd3) begin
                byte_idx_d = 2'd0;
                if (full_word == END_MARKER) begin
                    prog_ready_d = 1'b1;
                end else begin
                    imem_we_d    = 1'b1;
                    imem_addr_d  = count_q;
                    imem_wdata_d = full_word;
                    // last slot written: memory full, stop instead of wrapping
                    if (count_q == ADDR_LAST) prog_ready_d = 1'b1;
                    else                      count_d      = count_q + 1'b1;
                end
            end else begin
                word_d[{byte_idx_q, 3'b000} +: BYTE_W] = byte_data;
                byte_idx_d = byte_idx_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_idx_q   <= 2'd0;
            word_q       <= '0;
            count_q      <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            prog_ready_q <= 1'b0;
        end else begin
            byte_idx_q   <= byte_idx_d;
            word_q       <= word_d;
            count_q      <= count_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            prog_ready_q <= prog_ready_d;
        end
    end

    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign prog_ready = prog_ready_q;
    assign core_hold  = ~prog_ready_q;
endmodule
